rr_arb_lock: RTL and testbench



---
 rtl/rr_arb_lock.sv | 115 +++++++++++
 tb/tb_rr_arb_lock.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_lock.sv
// rr_arb_lock: registered N-way round-robin arbiter with grant lock; ARB_TIMEOUT_EN adds a hold limit and to_evict.
// Latency 1 cycle req->gnt; no backpressure, a grant is held until done, withdrawal, en low or (optional) timeout.
module rr_arb_lock #(
  parameter int NUM_REQ = 8,
  localparam int IDX_W = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
`ifdef ARB_TIMEOUT_EN
  output logic               to_evict,
`endif
  output logic               req_up
);

  if (NUM_REQ < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arb_lock: NUM_REQ must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   win_prev;
  logic [NUM_REQ-1:0] win_oh;
  logic               rel_cause;
  logic               rel_to;
  logic               rel;
  logic               grant_now;
  logic               drop_now;

  assign req_up = en & (|req);

  // Downward search with wrap starting at ptr; first set request wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = (cand == '0) ? IDX_W'(NUM_REQ - 1) : cand - 1'b1;
    end
  end

  assign win_prev = (win_idx == '0) ? IDX_W'(NUM_REQ - 1) : win_idx - 1'b1;
  assign win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD + 1);
  logic [HC_W-1:0] hold_cnt;

  // Timeout only counts as the cause when nothing else is releasing the grant.
  assign rel_to = (state == BUSY) && !rel_cause && (hold_cnt == HC_W'(MAX_HOLD - 1));
`else
  assign rel_to = 1'b0;
`endif

  always_comb begin
    rel_cause = done | ~req[gnt_idx] | ~en;
    rel       = (state == BUSY) && (rel_cause || rel_to);
    grant_now = en && win_vld && ((state == IDLE) || rel);
    drop_now  = rel && !grant_now;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      to_evict  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      to_evict <= rel_to;
`endif
      if (grant_now) begin
        state     <= BUSY;
        gnt       <= win_oh;
        gnt_valid <= 1'b1;
        gnt_idx   <= win_idx;
        ptr       <= win_prev;
`ifdef ARB_TIMEOUT_EN
        hold_cnt  <= '0;
`endif
      end else if (drop_now) begin
        state     <= IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_idx   <= '0;
      end
`ifdef ARB_TIMEOUT_EN
      else if (state == BUSY) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rr_arb_lock.sv
// Directed bench for rr_arb_lock (8 requesters, MAX_HOLD=4): rotation, lock, fairness, withdrawal, async reset, timeout.
module tb_rr_arb_lock;

  logic       clock;
  logic       reset_n;
  logic [7:0] req;
  logic       en;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       req_up;
`ifdef ARB_TIMEOUT_EN
  logic       to_evict;
`endif

  int n_vec = 0;
  int n_bad = 0;

  rr_arb_lock #(.NUM_REQ(8), .MAX_HOLD(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .en       (en),
    .done     (done),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
`ifdef ARB_TIMEOUT_EN
    .to_evict (to_evict),
`endif
    .req_up   (req_up)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_idx);
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(exp_gnt != 8'h00));
  endtask

  // Pulse reset between clock edges and leave inputs quiet.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    req = 8'h00; en = 1'b0; done = 1'b0;
    #1;
    chk_gnt("rst_async", 8'h00, 3'd0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt [8];
    logic [2:0] exp_i;

    reset_n = 1'b0; req = 8'h00; en = 1'b0; done = 1'b0;
    #12;
    chk_gnt("reset", 8'h00, 3'd0);
    chk("reset.req_up", 32'(req_up), 32'd0);
    reset_n = 1'b1;
    tick();

    // Reset default: highest index first, then rotation to 0.
    req = 8'b1000_0001; en = 1'b1;
    #1;
    chk("req_up.on", 32'(req_up), 32'd1);
    tick();
    chk_gnt("dflt.first", 8'b1000_0000, 3'd7);
    done = 1'b1;
    tick();
    chk_gnt("dflt.rot", 8'b0000_0001, 3'd0);

    // Hand over to 3, then lock it while everybody requests.
    req = 8'h08;
    tick();
    chk_gnt("lock.take3", 8'b0000_1000, 3'd3);
    req = 8'hFF; done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_gnt("lock.hold", 8'b0000_1000, 3'd3);
    end
    done = 1'b1;
    tick();
    chk_gnt("lock.b2b", 8'b0000_0100, 3'd2);

    // Async reset mid-grant, no clock edge, then pointer back at 7.
    done = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk_gnt("arst.mid", 8'h00, 3'd0);
    #1;
    reset_n = 1'b1;
    req = 8'b0000_0110; en = 1'b1;
    tick();
    chk_gnt("arst.after", 8'b0000_0100, 3'd2);

    // Fairness from fresh reset: 7..0 then 7.
    do_reset();
    req = 8'hFF; en = 1'b1; done = 1'b1;
    exp_i = 3'd7;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_gnt("fair", 8'h01 << exp_i, exp_i);
      if (i < 8) cnt[gnt_idx]++;
      exp_i = exp_i - 3'd1;
    end
    for (int i = 0; i < 8; i++) chk("fair.once", 32'(cnt[i]), 32'd1);

    // Withdrawal: holder 7 drops, 5 takes over, then 5 drops with nobody else.
    done = 1'b0; req = 8'h20;
    tick();
    chk_gnt("wd.to5", 8'b0010_0000, 3'd5);
    req = 8'h00;
    tick();
    chk_gnt("wd.idle", 8'h00, 3'd0);
    req = 8'h20;
    tick();
    chk_gnt("wd.regrant", 8'b0010_0000, 3'd5);

    // Enable low mid-grant: req_up drops at once, grant next edge, none while low.
    en = 1'b0;
    #1;
    chk("en.req_up", 32'(req_up), 32'd0);
    tick();
    chk_gnt("en.drop", 8'h00, 3'd0);
    tick();
    chk_gnt("en.idle", 8'h00, 3'd0);

`ifdef ARB_TIMEOUT_EN
    // Holder 1 with 0 also asking: forced off after 4 cycles, evict pulse.
    do_reset();
    en = 1'b1; req = 8'b0000_0010;
    tick();
    chk_gnt("to.grant", 8'b0000_0010, 3'd1);
    chk("to.evict0", 32'(to_evict), 32'd0);
    req = 8'b0000_0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_gnt("to.hold", 8'b0000_0010, 3'd1);
      chk("to.noevict", 32'(to_evict), 32'd0);
    end
    tick();
    chk_gnt("to.evicted", 8'b0000_0001, 3'd0);
    chk("to.pulse", 32'(to_evict), 32'd1);
    tick();
    chk("to.pulse_end", 32'(to_evict), 32'd0);
    chk_gnt("to.next", 8'b0000_0001, 3'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
